// File: rtl/round_sequencer.sv
// round_sequencer: grows a random action sequence, plays it out and checks player input
module round_sequencer #(
  parameter int          MAX_LEN   = 16,
  parameter logic [25:0] TIMEOUT   = 26'd50000000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_play_valid,
  input  logic       i_play_ready,
  output logic [2:0] o_play_code,
  input  logic       i_action_valid,
  input  logic [2:0] i_action_code,
  output logic [4:0] o_level,
  output logic [7:0] o_score,
  output logic       o_busy,
  output logic       o_lose,
  output logic       o_win
);
  localparam int AW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [5:0] LMAX = 6'(MAX_LEN);
  typedef enum logic [2:0] {S_IDLE, S_EXTEND, S_PLAY, S_INPUT, S_LOSE, S_WIN} state_t;
  state_t      r_state, w_state;
  logic [5:0]  r_level, w_level;
  logic [4:0]  r_idx, w_idx;
  logic [7:0]  r_score, w_score;
  logic [25:0] r_cnt, w_cnt;
  logic [7:0]  r_lfsr;
  logic [1:0]  r_mem [MAX_LEN];
  logic [2:0]  w_expect;
  logic        w_last, w_accept, w_match;
  assign w_expect = {1'b0, r_mem[r_idx[AW-1:0]]} + 3'd1;
  assign w_last   = {1'b0, r_idx} == r_level - 6'd1;
  assign w_accept = i_action_valid && i_action_code != 3'd0;
  assign w_match  = i_action_code == w_expect;
  assign o_play_valid = r_state == S_PLAY;
  assign o_play_code  = (r_state == S_PLAY) ? w_expect : 3'd0;
  assign o_level      = r_level[4:0];
  assign o_score      = r_score;
  assign o_busy       = r_state == S_EXTEND || r_state == S_PLAY || r_state == S_INPUT;
  assign o_lose       = r_state == S_LOSE;
  assign o_win        = r_state == S_WIN;
  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR; a non-zero seed keeps it out of the all-zero lockup
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  // Sequence storage holds code-1; contents need no reset since level gates every read
  always_ff @(posedge i_clk)
    if (r_state == S_EXTEND) r_mem[r_level[AW-1:0]] <= r_lfsr[1:0];
  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_idx   <= '0;
      r_score <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_level <= w_level;
      r_idx   <= w_idx;
      r_score <= w_score;
      r_cnt   <= w_cnt;
    end
  // Next-state logic: start only counts outside the busy states; a player action beats a same-cycle timeout
  always_comb begin
    w_state = r_state;
    w_level = r_level;
    w_idx   = r_idx;
    w_score = r_score;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE, S_LOSE, S_WIN:
        if (i_start) begin
          w_state = S_EXTEND;
          w_level = '0;
          w_score = '0;
        end
      S_EXTEND: begin
        w_level = r_level + 6'd1;
        w_idx   = '0;
        w_state = S_PLAY;
      end
      S_PLAY:
        if (i_play_ready) begin
          if (w_last) begin
            w_idx   = '0;
            w_cnt   = TIMEOUT;
            w_state = S_INPUT;
          end else w_idx = r_idx + 5'd1;
        end
      S_INPUT: begin
        w_cnt = r_cnt - 26'd1;
        if (w_accept) begin
          if (!w_match) w_state = S_LOSE;
          else begin
            w_score = r_score + {7'd0, r_score != 8'hFF};
            w_cnt   = TIMEOUT;
            if (w_last) w_state = (r_level == LMAX) ? S_WIN : S_EXTEND;
            else        w_idx   = r_idx + 5'd1;
          end
        end else if (r_cnt <= 26'd1) w_state = S_LOSE;
      end
      default: w_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed game scenarios with random codes/gaps checked against a queue model of the sequence
module tb_round_sequencer;
  logic clk, rst_n, start, ready, av;
  logic [2:0] ac;
  logic       a_pv, a_busy, a_lose, a_win, b_pv, b_busy, b_lose, b_win;
  logic [2:0] a_pc, b_pc;
  logic [4:0] a_lv, b_lv;
  logic [7:0] a_sc, b_sc;
  int checks = 0, errors = 0;
  int seq[$];
  int score_m = 0;

  round_sequencer #(.MAX_LEN(16), .TIMEOUT(26'd8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_play_valid(a_pv), .i_play_ready(ready),
    .o_play_code(a_pc), .i_action_valid(av), .i_action_code(ac), .o_level(a_lv), .o_score(a_sc),
    .o_busy(a_busy), .o_lose(a_lose), .o_win(a_win));
  round_sequencer #(.MAX_LEN(2), .TIMEOUT(26'd8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_play_valid(b_pv), .i_play_ready(ready),
    .o_play_code(b_pc), .i_action_valid(av), .i_action_code(ac), .o_level(b_lv), .o_score(b_sc),
    .o_busy(b_busy), .o_lose(b_lose), .o_win(b_win));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic play_round(input bit stall);
    int len;
    logic [2:0] held;
    len = seq.size() + 1;
    chk("play_level", a_lv, len);
    for (int i = 0; i < len; i++) begin
      chk("play_valid", a_pv, 1);
      if (i < seq.size()) chk("play_code", a_pc, seq[i]);
      else begin
        chk("play_code_range", a_pc >= 1 && a_pc <= 4, 1);
        seq.push_back(int'(a_pc));
      end
      if (stall && i == 0) begin
        ready = 0;
        held = a_pc;
        repeat (5) begin
          tick;
          chk("stall_valid", a_pv, 1);
          chk("stall_code", a_pc, held);
        end
        ready = 1;
      end
      tick;
    end
    chk("play_done_valid", a_pv, 0);
    chk("play_done_busy", a_busy, 1);
  endtask

  task automatic echo_round;
    for (int i = 0; i < seq.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        av = 1; ac = 0;
        tick;
        av = 0;
      end
      repeat ($urandom_range(0, 2)) tick;
      av = 1; ac = 3'(seq[i]);
      tick;
      av = 0;
      score_m++;
      if (i < seq.size() - 1) chk("echo_score", a_sc, score_m);
    end
  endtask

  task automatic wrong_action;
    int w;
    do w = $urandom_range(1, 7); while (w == seq[0]);
    av = 1; ac = 3'(w);
    tick;
    av = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; ready = 1; av = 0; ac = 0;
    repeat (3) tick;
    chk("rst_valid", a_pv, 0);
    chk("rst_code", a_pc, 0);
    chk("rst_level", a_lv, 0);
    chk("rst_score", a_sc, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_lose", a_lose, 0);
    chk("rst_win", a_win, 0);
    rst_n = 1;
    tick;
    // game 1: three echoed rounds, B wins at its MAX_LEN of 2, A then fails on a wrong code
    start = 1;
    tick;
    start = 0;
    chk("ext_busy", a_busy, 1);
    chk("ext_valid", a_pv, 0);
    tick;
    chk("first_valid", a_pv, 1);
    chk("first_level", a_lv, 1);
    chk("first_code_range", a_pc >= 1 && a_pc <= 4, 1);
    seq.push_back(int'(a_pc));
    start = 1;
    tick;
    start = 0;
    chk("first_valid_drop", a_pv, 0);
    chk("busy_start_level", a_lv, 1);
    chk("busy_start_busy", a_busy, 1);
    chk("busy_start_b", b_busy, 1);
    for (int r = 1; r <= 3; r++) begin
      echo_round;
      chk("round_score", a_sc, score_m);
      chk("round_level", a_lv, seq.size());
      chk("round_valid", a_pv, 0);
      chk("round_lose", a_lose, 0);
      if (r == 2) begin
        chk("b_win", b_win, 1);
        chk("b_score", b_sc, 3);
        chk("b_busy", b_busy, 0);
        chk("b_level", b_lv, 2);
      end
      tick;
      play_round(r == 1);
    end
    chk("g1_score6", a_sc, 6);
    chk("b_still_win", b_win, 1);
    wrong_action;
    chk("wrong_lose", a_lose, 1);
    chk("wrong_level", a_lv, 4);
    chk("wrong_score", a_sc, 6);
    chk("wrong_busy", a_busy, 0);
    // game 2: mismatch on the first action of round 2
    start = 1;
    tick;
    start = 0;
    seq.delete();
    score_m = 0;
    chk("restart_score", a_sc, 0);
    chk("restart_lose", a_lose, 0);
    tick;
    play_round(0);
    echo_round;
    tick;
    play_round(0);
    wrong_action;
    chk("r2_lose", a_lose, 1);
    chk("r2_level", a_lv, 2);
    chk("r2_score", a_sc, 1);
    chk("r2_b_lose", b_lose, 1);
    // game 3: action on the last allowed cycle still counts, then a full timeout loses
    start = 1;
    tick;
    start = 0;
    seq.delete();
    score_m = 0;
    tick;
    chk("g3_level", a_lv, 1);
    play_round(0);
    tick; tick;
    av = 1; ac = 0;
    tick;
    av = 0;
    repeat (4) tick;
    chk("late_not_lost", a_lose, 0);
    av = 1; ac = 3'(seq[0]);
    tick;
    av = 0;
    chk("late_accept_lose", a_lose, 0);
    chk("late_accept_score", a_sc, 1);
    chk("late_accept_busy", a_busy, 1);
    tick;
    play_round(0);
    repeat (7) tick;
    chk("to_before", a_lose, 0);
    tick;
    chk("to_lose", a_lose, 1);
    chk("to_level", a_lv, 2);
    chk("to_score", a_sc, 1);
    // game 4: asynchronous reset in the middle of PLAY
    start = 1;
    tick;
    start = 0;
    tick;
    chk("pre_rst_valid", a_pv, 1);
    rst_n = 0;
    #1;
    chk("async_valid", a_pv, 0);
    chk("async_code", a_pc, 0);
    chk("async_busy", a_busy, 0);
    chk("async_level", a_lv, 0);
    tick;
    rst_n = 1;
    tick;
    chk("post_rst_level", a_lv, 0);
    chk("post_rst_busy", a_busy, 0);
    tick;
    chk("post_rst_idle", a_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
